// File: rtl/alu_pipe_pkg.sv
// Shared constants for alu_pipe: opcode encodings, FSM state encoding and
// bit positions inside the flags vector.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_pipe_mul.sv
// Unsigned shift-add multiplier: one partial product per clock for WIDTH clocks.
// done flags the cycle whose closing edge performs the final step.
module alu_pipe_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      product <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= STEPS;
    end else if (cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // product stays frozen once cnt reaches zero, until the next start
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle datapath for logic/arith/shift ops, a
// multi-cycle shift-add multiplier for MUL, results held until consumed.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   op,
  input  logic [3:0]           aluc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     res,
  output logic [WIDTH-1:0]     res_hi,
  output logic [3:0]           flags,
  output logic                 err
);

  localparam int SW = $clog2(WIDTH);

  state_e state, state_nx;

  logic [WIDTH-1:0]   a, b;
  logic [SW-1:0]      sh;
  logic               accept, is_mul, mul_done, sel_mul;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   d_res, res_q;
  logic               d_carry, d_ovf, d_err, err_q;
  logic [3:0]         flags_q, mul_flags;

  assign a        = op[2*WIDTH-1:WIDTH];
  assign b        = op[WIDTH-1:0];
  assign sh       = b[SW-1:0];
  assign is_mul   = (aluc == OP_MUL);
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (accept)         state_nx = is_mul ? ST_BUSY : ST_DONE;
        else if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    d_res   = '0;
    d_carry = 1'b0;
    d_ovf   = 1'b0;
    d_err   = 1'b0;
    case (aluc)
      OP_ADD: begin
        d_res   = sum[WIDTH-1:0];
        d_carry = sum[WIDTH];
        d_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        d_res   = diff[WIDTH-1:0];
        d_carry = diff[WIDTH];
        d_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  d_res = a & b;
      OP_OR:   d_res = a | b;
      OP_XOR:  d_res = a ^ b;
      OP_NOR:  d_res = ~(a | b);
      OP_SLT:  d_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: d_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  d_res = a << sh;
      OP_SRL:  d_res = a >> sh;
      OP_SRA:  d_res = $signed(a) >>> sh;
      OP_MUL:  d_res = '0;
      default: d_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (accept && !is_mul) begin
      res_q                <= d_res;
      flags_q[FLAG_ZERO]   <= (d_res == '0);
      flags_q[FLAG_NEG]    <= d_res[WIDTH-1];
      flags_q[FLAG_CARRY]  <= d_carry;
      flags_q[FLAG_OVF]    <= d_ovf;
      err_q                <= d_err;
    end
  end

  // MUL results are read straight from the frozen multiplier accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sel_mul <= 1'b0;
    else if (accept) sel_mul <= is_mul;
  end

  always_comb begin
    mul_flags             = '0;
    mul_flags[FLAG_ZERO]  = (product == '0);
    mul_flags[FLAG_NEG]   = product[2*WIDTH-1];
  end

  assign res    = sel_mul ? product[WIDTH-1:0]       : res_q;
  assign res_hi = sel_mul ? product[2*WIDTH-1:WIDTH] : '0;
  assign flags  = sel_mul ? mul_flags                : flags_q;
  assign err    = sel_mul ? 1'b0                     : err_q;

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=4): directed vectors, handshake
// corner sequences and random ops against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic [3:0]   flags;
    logic         err;
  } exp_t;

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] op = '0;
  logic [3:0]     aluc = '0;
  logic           in_ready, out_valid, err;
  logic [W-1:0]   res, res_hi;
  logic [3:0]     flags;

  int n_cmp = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_hi    (res_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, " res"},    res,    e.res);
    chk({name, " res_hi"}, res_hi, e.res_hi);
    chk({name, " flags"},  flags,  e.flags);
    chk({name, " err"},    err,    e.err);
  endtask

  // Arithmetic reference: plain integers, signed views by subtracting 2^W.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint m, ua, ub, sa, sb, r, hi, s;
    int     sh;
    logic   cy, ov;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    sh = int'(ub % W);
    r = 0; hi = 0; cy = 0; ov = 0;
    e.err = 1'b0;
    case (c)
      4'd0: begin r = (ua + ub) % m; cy = (ua + ub) >= m; s = sa + sb; ov = (s >= m/2) || (s < -m/2); end
      4'd1: begin r = (ua - ub + m) % m; cy = ua < ub; s = sa - sb; ov = (s >= m/2) || (s < -m/2); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (m - 1) & ~(ua | ub);
      4'd6: r = (sa < sb) ? 1 : 0;
      4'd7: r = (ua < ub) ? 1 : 0;
      4'd8: r = (ua << sh) % m;
      4'd9: r = ua >> sh;
      4'd10: r = (sa >>> sh) & (m - 1);
      4'd11: begin s = ua * ub; r = s % m; hi = s / m; end
      default: e.err = 1'b1;
    endcase
    e.res    = r[W-1:0];
    e.res_hi = hi[W-1:0];
    e.flags  = {(r == 0 && hi == 0), (c == 4'd11) ? hi[W-1] : r[W-1], cy, ov};
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic [3:0] f, input logic e);
    vec_t v;
    v.c = c; v.a = a; v.b = b;
    v.e.res = r; v.e.res_hi = h; v.e.flags = f; v.e.err = e;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int lat;
    in_valid = 1'b1; aluc = c; op = {a, b}; out_ready = 1'b1;
    #1 chk({name, " in_ready idle"}, in_ready, 1);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk({name, " in_ready busy"}, in_ready, 0);
      aluc = 4'($urandom);
      op = (2*W)'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, lat, (c == 4'b1011) ? W + 1 : 1);
    check_out(name, e);
    @(negedge clk);
    chk({name, " consumed"}, out_valid, 0);
  endtask

  vec_t tv[$];
  exp_t ex;

  initial begin
    tv.push_back(mk(4'b0000, 4'b1010, 4'b1011, 4'b0101, 4'b0000, 4'b0011, 1'b0)); // ADD
    tv.push_back(mk(4'b0001, 4'b1010, 4'b1011, 4'b1111, 4'b0000, 4'b0110, 1'b0)); // SUB
    tv.push_back(mk(4'b1010, 4'b1010, 4'b0001, 4'b1101, 4'b0000, 4'b0100, 1'b0)); // SRA
    tv.push_back(mk(4'b1011, 4'b1010, 4'b1011, 4'b1110, 4'b0110, 4'b0000, 1'b0)); // MUL
    tv.push_back(mk(4'b1111, 4'b1010, 4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b1)); // illegal
    tv.push_back(mk(4'b1100, 4'b0111, 4'b0011, 4'b0000, 4'b0000, 4'b1000, 1'b1)); // illegal
    tv.push_back(mk(4'b0010, 4'b1010, 4'b1011, 4'b1010, 4'b0000, 4'b0100, 1'b0)); // AND
    tv.push_back(mk(4'b0011, 4'b1010, 4'b1011, 4'b1011, 4'b0000, 4'b0100, 1'b0)); // OR
    tv.push_back(mk(4'b0100, 4'b1010, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b0)); // XOR
    tv.push_back(mk(4'b0101, 4'b1010, 4'b1011, 4'b0100, 4'b0000, 4'b0000, 1'b0)); // NOR
    tv.push_back(mk(4'b0110, 4'b1010, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b0)); // SLT
    tv.push_back(mk(4'b0110, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0)); // SLT 3 < -8
    tv.push_back(mk(4'b0111, 4'b0011, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 1'b0)); // SLTU
    tv.push_back(mk(4'b1000, 4'b1010, 4'b0011, 4'b0000, 4'b0000, 4'b1000, 1'b0)); // SLL
    tv.push_back(mk(4'b1001, 4'b1010, 4'b0111, 4'b0001, 4'b0000, 4'b0000, 1'b0)); // SRL, upper b ignored
    tv.push_back(mk(4'b0000, 4'b0111, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 1'b0)); // ADD ovf only
    tv.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0)); // SUB zero
    tv.push_back(mk(4'b1011, 4'b1111, 4'b1111, 4'b0001, 4'b1110, 4'b0100, 1'b0)); // MUL max
    tv.push_back(mk(4'b1011, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1000, 1'b0)); // MUL zero

    // reset state
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset res", res, 0);
    chk("reset res_hi", res_hi, 0);
    chk("reset flags", flags, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    #1 chk("reset in_ready after release", in_ready, 1);
    @(negedge clk);

    foreach (tv[i])
      run_op($sformatf("vec%0d", i), tv[i].c, tv[i].a, tv[i].b, tv[i].e);

    // result held while out_ready is low, then take + new accept on the same edge
    in_valid = 1'b1; aluc = 4'b0000; op = 8'b1010_1011; out_ready = 1'b0;
    @(negedge clk);
    aluc = 4'b0001; op = 8'b0110_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d out_valid", k), out_valid, 1);
      chk($sformatf("stall%0d in_ready", k), in_ready, 0);
      chk($sformatf("stall%0d res", k), res, 4'b0101);
      chk($sformatf("stall%0d flags", k), flags, 4'b0011);
      @(negedge clk);
    end
    aluc = 4'b0010; op = 8'b1010_1011; out_ready = 1'b1;
    #1 chk("b2b in_ready", in_ready, 1);
    @(negedge clk);
    chk("b2b out_valid", out_valid, 1);
    chk("b2b res", res, 4'b1010);
    chk("b2b flags", flags, 4'b0100);
    aluc = 4'b1011; op = 8'b1010_1011;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b mul busy out_valid", out_valid, 0);
    chk("b2b mul busy in_ready", in_ready, 0);
    begin
      int lat = 1;
      while (!out_valid && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b mul latency", lat, W + 1);
    end
    ex.res = 4'b1110; ex.res_hi = 4'b0110; ex.flags = 4'b0000; ex.err = 1'b0;
    check_out("b2b mul", ex);
    @(negedge clk);

    // reset in the middle of a multiply discards it
    in_valid = 1'b1; aluc = 4'b1011; op = 8'b1111_1111; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst res", res, 0);
    chk("midrst res_hi", res_hi, 0);
    chk("midrst flags", flags, 0);
    chk("midrst err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst in_ready", in_ready, 1);
    begin
      int seen = 0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst no result", seen, 0);
    end

    // random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   c;
      logic [W-1:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      run_op($sformatf("rand%0d c=%0h a=%0h b=%0h", i, c, a, b), c, a, b, model(c, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width; legal values 4, 8, 16, 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands/opcode presented.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready at clk edge.
REQ-006 SHALL have port op  input  2*WIDTH  packed operands {op1, op2}, op1 in upper half.
REQ-007 SHALL have port aluc  input  4  opcode.
REQ-008 SHALL have port out_valid  output  1  result held stable.
REQ-009 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-010 SHALL have port res  output  WIDTH  result (MUL: low half).
REQ-011 SHALL have port res_hi  output  WIDTH  MUL high half; 0 for all other ops.
REQ-012 SHALL have port flags  output  4  {zero, neg, carry, ovf}.
REQ-013 SHALL have port err  output  1  illegal opcode accepted.

Function
REQ-014 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT signed, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 MUL unsigned; 1100-1111 illegal.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready = (IDLE) or (DONE && out_ready); out_valid = DONE.
REQ-016 Non-MUL accepted op: captured into output registers at accept edge; DONE next cycle (latency 1).
REQ-017 MUL accepted: enter BUSY, shift-add one bit per cycle for WIDTH cycles, then DONE (out_valid WIDTH+1 cycles after accept edge).
REQ-018 BUSY ignores in_valid; operands latched at accept, later op changes have no effect.
REQ-019 DONE holds res/res_hi/flags/err stable until out_ready; on out_valid && out_ready with no new accept -> IDLE.
REQ-020 DONE with out_ready and in_valid same edge: new op accepted, back-to-back (non-MUL -> DONE, MUL -> BUSY).
REQ-021 ADD/SUB modulo 2^WIDTH; carry = ADD carry-out or SUB borrow (op1 < op2 unsigned); ovf = signed overflow; both 0 for other ops.
REQ-022 SLT/SLTU: res = 1 if op1 < op2 (signed/unsigned), else 0.
REQ-023 Shifts: amount = op2[log2(WIDTH)-1:0], upper op2 bits ignored; SRA sign-fills.
REQ-024 zero = 1 when res (and res_hi for MUL) all zero; neg = res MSB (MUL: res_hi MSB).
REQ-025 Illegal opcode: res = 0, res_hi = 0, flags = 0100... no: flags = {1,0,0,0}, err = 1, latency 1; err = 0 for legal ops.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, out_valid 0, res 0, res_hi 0, flags 0, err 0, multiplier state 0.
REQ-027 Reset during BUSY or DONE SHALL discard the operation; no result is ever presented for it.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Package alu_pipe_pkg SHALL hold the aluc opcode constants, state encoding, and flag bit indices.
REQ-030 Shift-add multiplier SHALL be sub-module alu_pipe_mul (start, operands, done, 2*WIDTH product).
REQ-031 Combinational single-cycle datapath SHALL reside in alu_pipe; no latches; one always-block per register group.

Verification (WIDTH=4, op1=1010, op2=1011)
REQ-032 ADD, out_ready=1 -> 1 cycle later res=0101, flags zero0 neg0 carry1 ovf1, err0.
REQ-033 SUB -> res=1111, carry1 (borrow), ovf0, neg1; then SRA with op2=0001 -> res=1101.
REQ-034 MUL -> out_valid 5 cycles after accept, res_hi=0110, res=1110, in_ready 0 during BUSY.
REQ-035 ADD with out_ready=0 for 3 cycles -> outputs stable, in_ready 0; out_ready + in_valid AND same edge -> next cycle res=1010, out_valid stays 1.
REQ-036 aluc=1111 -> res=0, err=1, zero=1; then rst_n pulse mid-MUL -> all outputs 0, no result emitted, in_ready=1 after release.
